// File: rtl/cache_lru_nway.sv
// rtl/cache_lru_nway.sv - parametrised true-LRU tracker, RAM-backed, self-initialising (optional CACHE_LRU_DEMOTE_EN)
module cache_lru_nway #(
    parameter int WAYS     = 4,
    parameter int SET_BITS = 9,
    parameter int WAY_BITS = $clog2(WAYS)
) (
    input  logic                main_clk,
    input  logic                reset,
    output logic                ready,
    input  logic                access_valid,
    input  logic [SET_BITS-1:0] addr,
    input  logic                touch,
    input  logic [WAY_BITS-1:0] used_index,
`ifdef CACHE_LRU_DEMOTE_EN
    input  logic                demote,
`endif
    output logic                lru_valid,
    output logic [WAY_BITS-1:0] least_used_index
);

    localparam int VEC_W = WAYS * WAY_BITS;
    localparam int DEPTH = 1 << SET_BITS;

    typedef enum logic {S_INIT, S_RUN} state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [SET_BITS-1:0] r_counter;
    logic                w_init_we;
    logic [VEC_W-1:0]    w_init_vec;

    logic                w_accept;
    logic                r_s1_valid;
    logic [SET_BITS-1:0] r_s1_addr;
    logic                r_s1_touch;
    logic [WAY_BITS-1:0] r_s1_used;
    logic                w_demote;

    logic [VEC_W-1:0]    r_mem [0:DEPTH-1];
    logic [VEC_W-1:0]    r_rd_data;
    logic [VEC_W-1:0]    r_fwd_data;
    logic                r_fwd_hit;

    logic                w_we;
    logic                w_run_we;
    logic [SET_BITS-1:0] w_waddr;
    logic [VEC_W-1:0]    w_wdata;

    logic [VEC_W-1:0]    w_cur;
    logic [VEC_W-1:0]    w_new_vec;
    logic [WAY_BITS-1:0] w_a;
    logic [WAY_BITS-1:0] w_lru;

    assign ready    = (r_state == S_RUN);
    assign w_accept = access_valid & ready;

`ifdef CACHE_LRU_DEMOTE_EN
    logic r_s1_demote;

    // Demote request rides along with the rest of the stage-1 access fields
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_s1_demote <= 1'b0;
        end else begin
            r_s1_demote <= demote;
        end
    end

    assign w_demote = r_s1_demote;
`else
    assign w_demote = 1'b0;
`endif

    // Reset vector: way i gets age WAYS-1-i, making way 0 the LRU
    always_comb begin
        w_init_vec = '0;
        for (int i = 0; i < WAYS; i++) begin
            w_init_vec[i*WAY_BITS +: WAY_BITS] = WAY_BITS'(WAYS - 1 - i);
        end
    end

    // FSM state and sweep counter
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_counter <= '0;
        end else begin
            r_state <= w_state_next;
            if (w_init_we) begin
                r_counter <= r_counter + SET_BITS'(1);
            end
        end
    end

    // FSM next state: sweep every set once, then run
    always_comb begin
        w_state_next = r_state;
        w_init_we    = 1'b0;
        case (r_state)
            S_INIT: begin
                w_init_we = 1'b1;
                if (r_counter == {SET_BITS{1'b1}}) begin
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_state_next = S_RUN;
            end
            default: begin
                w_state_next = S_INIT;
            end
        endcase
    end

    // Stage 1: capture the access while the RAM read is in flight
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_addr  <= '0;
            r_s1_touch <= 1'b0;
            r_s1_used  <= '0;
            r_fwd_hit  <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            r_s1_addr  <= addr;
            r_s1_touch <= touch;
            r_s1_used  <= used_index;
            r_fwd_hit  <= w_we && (w_waddr == addr);
        end
    end

    // Single write port shared by the init sweep and the touch update
    assign w_run_we = r_s1_valid & r_s1_touch;
    assign w_we     = w_init_we | w_run_we;
    assign w_waddr  = w_init_we ? r_counter : r_s1_addr;
    assign w_wdata  = w_init_we ? w_init_vec : w_new_vec;

    // Age RAM; the write landing with the read is captured for forwarding
    always_ff @(posedge main_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rd_data  <= r_mem[addr];
        r_fwd_data <= w_wdata;
    end

    // Find the LRU way and build the updated age vector
    always_comb begin
        w_cur     = r_fwd_hit ? r_fwd_data : r_rd_data;
        w_a       = '0;
        w_lru     = '0;
        w_new_vec = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (WAY_BITS'(i) == r_s1_used) begin
                w_a = w_cur[i*WAY_BITS +: WAY_BITS];
            end
            if (w_cur[i*WAY_BITS +: WAY_BITS] == WAY_BITS'(WAYS - 1)) begin
                w_lru = WAY_BITS'(i);
            end
        end
        for (int i = 0; i < WAYS; i++) begin
            w_new_vec[i*WAY_BITS +: WAY_BITS] = w_cur[i*WAY_BITS +: WAY_BITS];
            if (WAY_BITS'(i) == r_s1_used) begin
                w_new_vec[i*WAY_BITS +: WAY_BITS] = w_demote ? WAY_BITS'(WAYS - 1) : '0;
            end else if (w_demote) begin
                if (w_cur[i*WAY_BITS +: WAY_BITS] > w_a) begin
                    w_new_vec[i*WAY_BITS +: WAY_BITS] = w_cur[i*WAY_BITS +: WAY_BITS] - WAY_BITS'(1);
                end
            end else begin
                if (w_cur[i*WAY_BITS +: WAY_BITS] < w_a) begin
                    w_new_vec[i*WAY_BITS +: WAY_BITS] = w_cur[i*WAY_BITS +: WAY_BITS] + WAY_BITS'(1);
                end
            end
        end
    end

    // Stage 2: register the pre-update LRU way
    always_ff @(posedge main_clk or posedge reset) begin
        if (reset) begin
            lru_valid        <= 1'b0;
            least_used_index <= '0;
        end else begin
            lru_valid        <= r_s1_valid;
            least_used_index <= w_lru;
        end
    end

endmodule

// File: tb/tb_cache_lru_nway.sv
// tb/tb_cache_lru_nway.sv - scoreboard bench for cache_lru_nway (WAYS=4, SET_BITS=9)
module tb_cache_lru_nway;

    logic       main_clk;
    logic       reset;
    logic       ready;
    logic       access_valid;
    logic [8:0] addr;
    logic       touch;
    logic [1:0] used_index;
    logic       demote;
    logic       lru_valid;
    logic [1:0] least_used_index;

    typedef struct {
        logic [1:0] idx;
        int         due;
        string      name;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc   = 0;

    cache_lru_nway #(.WAYS(4), .SET_BITS(9)) dut (
        .main_clk         (main_clk),
        .reset            (reset),
        .ready            (ready),
        .access_valid     (access_valid),
        .addr             (addr),
        .touch            (touch),
        .used_index       (used_index),
`ifdef CACHE_LRU_DEMOTE_EN
        .demote           (demote),
`endif
        .lru_valid        (lru_valid),
        .least_used_index (least_used_index)
    );

    initial begin
        main_clk = 1'b0;
        forever #5 main_clk = ~main_clk;
    end

    always @(posedge main_clk) cyc = cyc + 1;

    always @(negedge main_clk) begin
        exp_t e;
        if (lru_valid === 1'b1) begin
            n_cmp = n_cmp + 1;
            if (sb.size() == 0) begin
                n_err = n_err + 1;
                $display("FAIL unexpected_lru_valid cyc=%0d got idx=%0d required no output", cyc, least_used_index);
            end else begin
                e = sb.pop_front();
                if (least_used_index !== e.idx) begin
                    n_err = n_err + 1;
                    $display("FAIL %s got=%0d required=%0d", e.name, least_used_index, e.idx);
                end
                n_cmp = n_cmp + 1;
                if (cyc != e.due) begin
                    n_err = n_err + 1;
                    $display("FAIL %s_latency got_cyc=%0d required_cyc=%0d", e.name, cyc, e.due);
                end
            end
        end
    end

    task automatic chk(input string name, input int got, input int req);
        n_cmp = n_cmp + 1;
        if (got != req) begin
            n_err = n_err + 1;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic acc(input string name, input int a, input bit t, input int u, input bit d, input int exp_idx);
        exp_t e;
        access_valid = 1'b1;
        addr         = 9'(a);
        touch        = t;
        used_index   = 2'(u);
        demote       = d;
        e.idx  = 2'(exp_idx);
        e.due  = cyc + 2;
        e.name = name;
        sb.push_back(e);
        @(posedge main_clk);
        #1;
    endtask

    task automatic idle(input int n);
        access_valid = 1'b0;
        touch        = 1'b0;
        demote       = 1'b0;
        repeat (n) begin
            @(posedge main_clk);
            #1;
        end
    endtask

    task automatic wait_ready(input string name);
        int n;
        n = 0;
        while (ready !== 1'b1 && n < 1000) begin
            @(posedge main_clk);
            #1;
            n = n + 1;
        end
        chk(name, n, 512);
    endtask

    initial begin
        reset        = 1'b1;
        access_valid = 1'b1;
        addr         = 9'd5;
        touch        = 1'b0;
        used_index   = 2'd0;
        demote       = 1'b0;
        repeat (3) @(posedge main_clk);
        #1;
        chk("rst_ready", int'(ready), 0);
        chk("rst_lru_valid", int'(lru_valid), 0);
        chk("rst_least_used_index", int'(least_used_index), 0);
        reset = 1'b0;

        wait_ready("init_cycles");
        acc("set5_lookup", 5, 0, 0, 0, 0);

        acc("set7_t0", 7, 1, 0, 0, 0);
        acc("set7_t1", 7, 1, 1, 0, 1);
        acc("set7_t2", 7, 1, 2, 0, 2);
        acc("set7_t3", 7, 1, 3, 0, 3);
        acc("set7_look", 7, 0, 0, 0, 0);

        acc("set7_t2a", 7, 1, 2, 0, 0);
        acc("set7_t2b", 7, 1, 2, 0, 0);
        acc("set7_look2", 7, 0, 0, 0, 0);
        idle(1);
        acc("set7_look3", 7, 0, 0, 0, 0);

        acc("set3_t0", 3, 1, 0, 0, 0);
        acc("set4_t0", 4, 1, 0, 0, 0);
        acc("set3_t1", 3, 1, 1, 0, 1);
        acc("set4_t1", 4, 1, 1, 0, 1);
        acc("set3_look", 3, 0, 0, 0, 2);
        acc("set4_look", 4, 0, 0, 0, 2);
        idle(4);

`ifdef CACHE_LRU_DEMOTE_EN
        acc("set9_t0", 9, 1, 0, 0, 0);
        acc("set9_t1", 9, 1, 1, 0, 1);
        acc("set9_t2", 9, 1, 2, 0, 2);
        acc("set9_t3", 9, 1, 3, 0, 3);
        acc("set9_demote2", 9, 1, 2, 1, 0);
        acc("set9_look", 9, 0, 0, 0, 2);
        acc("set9_demote_notouch", 9, 0, 1, 1, 2);
        acc("set9_look2", 9, 0, 0, 0, 2);
        idle(4);
`endif

        acc("mid_t0", 7, 1, 0, 0, 0);
        acc("mid_t1", 7, 1, 1, 0, 1);
        acc("mid_t2", 7, 1, 2, 0, 2);
        acc("mid_t3", 7, 1, 3, 0, 3);
        reset = 1'b1;
        #1;
        sb.delete();
        chk("midrst_lru_valid", int'(lru_valid), 0);
        chk("midrst_ready", int'(ready), 0);
        access_valid = 1'b1;
        addr         = 9'd7;
        touch        = 1'b0;
        @(posedge main_clk);
        #1;
        reset = 1'b0;
        wait_ready("reinit_cycles");
        acc("reinit_set7", 7, 0, 0, 0, 0);
        acc("reinit_set0", 0, 0, 0, 0, 0);
        acc("reinit_set3", 3, 0, 0, 0, 0);
        acc("reinit_set4", 4, 0, 0, 0, 0);
        acc("reinit_set511", 511, 0, 0, 0, 0);
        acc("reinit_set7_t3", 7, 1, 3, 0, 0);
        acc("reinit_set7_look", 7, 0, 0, 0, 0);
        idle(5);

        chk("scoreboard_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
